riscv_fetch_queue: RTL and testbench

Parametrised, tag-aware instruction queue between the prefetch buffer and the IF/ID pipeline registers. It generalises the single-slot IF buffering to DEPTH entries. Each entry carries the instruction word, its PC, a DIFT tag of TAG_WIDTH bits and the hwloop flag. Adds optional zero-latency fall-through, flush on PC redirect, and tagged-PC fault detection with a sticky status bit.

---
 rtl/riscv_fetch_queue.sv | 94 +++++++++
 tb/tb_riscv_fetch_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: tag-aware circular instruction queue between prefetch buffer and IF/ID
module riscv_fetch_queue #(
  parameter int DEPTH       = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 1,
  parameter int FALLTHROUGH = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_WIDTH-1:0]      in_rdata_i,
  input  logic [31:0]                in_addr_i,
  input  logic [TAG_WIDTH-1:0]       in_tag_i,
  input  logic                       in_is_hwlp_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      out_rdata_o,
  output logic [31:0]                out_addr_o,
  output logic [TAG_WIDTH-1:0]       out_tag_o,
  output logic                       out_is_hwlp_o,
  input  logic                       tag_check_en_i,
  output logic                       tag_fault_o,
  output logic                       fault_sticky_o,
  input  logic                       fault_clr_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic [31:0]           addr;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  is_hwlp;
  } entry_t;
  entry_t        mem [DEPTH];
  entry_t        in_e, head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          bypass, push, pop, wr_en, rd_en;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign in_e          = {in_rdata_i, in_addr_i, in_tag_i, in_is_hwlp_i};
  assign bypass        = (FALLTHROUGH != 0) && (count == '0);
  assign in_ready_o    = (count < CW'(DEPTH)) & ~flush_i;
  assign out_valid_o   = ~flush_i & (bypass ? in_valid_i : (count != '0));
  assign head          = bypass ? in_e : mem[rd_ptr];
  assign out_rdata_o   = head.rdata;
  assign out_addr_o    = head.addr;
  assign out_tag_o     = head.tag;
  assign out_is_hwlp_o = head.is_hwlp;
  assign tag_fault_o   = out_valid_o & tag_check_en_i & (|head.tag);
  assign push          = in_valid_i & in_ready_o;
  assign pop           = out_valid_o & out_ready_i;
  // a word consumed straight from the inputs never occupies a slot
  assign wr_en         = push & ~(bypass & pop);
  assign rd_en         = pop & ~bypass;
  assign count_o       = count;
  // pointer and occupancy state; flush returns the queue to its reset layout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= nxt(wr_ptr);
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
  // entry storage, written as a whole so fields never separate
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_e;
  end
  // sticky fault: set on popping a faulting head, set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_sticky_o <= 1'b0;
    else if (pop & tag_fault_o) fault_sticky_o <= 1'b1;
    else if (fault_clr_i) fault_sticky_o <= 1'b0;
  end
  // overflow/underflow are impossible by construction
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && count == CW'(DEPTH)));
      assert (!(rd_en && count == '0));
    end
  end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb_riscv_fetch_queue: directed self-checking bench for riscv_fetch_queue
module tb_riscv_fetch_queue;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, hwlp = 0, out_ready = 0;
  logic        chk_en = 0, clr = 0;
  logic [31:0] rdata = 0, addr = 0;
  logic [0:0]  tag = 0;
  int          n_chk = 0, n_fail = 0;

  logic        ir4, ov4, oh4, tf4, st4;
  logic [31:0] od4, oa4;
  logic [0:0]  ot4;
  logic [2:0]  c4;
  logic        ir3, ov3, oh3, tf3, st3;
  logic [31:0] od3, oa3;
  logic [0:0]  ot3;
  logic [1:0]  c3;
  logic        irf, ovf, ohf, tff, stf;
  logic [31:0] odf, oaf;
  logic [0:0]  otf;
  logic [2:0]  cf;

  always #5 clk = ~clk;

  riscv_fetch_queue #(.DEPTH(4), .FALLTHROUGH(0)) u4 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir4),
    .in_rdata_i(rdata), .in_addr_i(addr), .in_tag_i(tag), .in_is_hwlp_i(hwlp),
    .out_valid_o(ov4), .out_ready_i(out_ready), .out_rdata_o(od4), .out_addr_o(oa4),
    .out_tag_o(ot4), .out_is_hwlp_o(oh4), .tag_check_en_i(chk_en), .tag_fault_o(tf4),
    .fault_sticky_o(st4), .fault_clr_i(clr), .count_o(c4));

  riscv_fetch_queue #(.DEPTH(3), .FALLTHROUGH(0)) u3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir3),
    .in_rdata_i(rdata), .in_addr_i(addr), .in_tag_i(tag), .in_is_hwlp_i(hwlp),
    .out_valid_o(ov3), .out_ready_i(out_ready), .out_rdata_o(od3), .out_addr_o(oa3),
    .out_tag_o(ot3), .out_is_hwlp_o(oh3), .tag_check_en_i(chk_en), .tag_fault_o(tf3),
    .fault_sticky_o(st3), .fault_clr_i(clr), .count_o(c3));

  riscv_fetch_queue #(.DEPTH(4), .FALLTHROUGH(1)) uf (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(irf),
    .in_rdata_i(rdata), .in_addr_i(addr), .in_tag_i(tag), .in_is_hwlp_i(hwlp),
    .out_valid_o(ovf), .out_ready_i(out_ready), .out_rdata_o(odf), .out_addr_o(oaf),
    .out_tag_o(otf), .out_is_hwlp_o(ohf), .tag_check_en_i(chk_en), .tag_fault_o(tff),
    .fault_sticky_o(stf), .fault_clr_i(clr), .count_o(cf));

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    #1;
    rst_n = 1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] a);
    in_valid = v;
    rdata = d;
    addr = a;
  endtask

  initial begin
    #12;
    chk("rst_count", c4, 0);
    chk("rst_valid", ov4, 0);
    chk("rst_ready", ir4, 1);
    chk("rst_fault", tf4, 0);
    chk("rst_sticky", st4, 0);
    chk("rst_count3", c3, 0);
    chk("rst_validf", ovf, 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hA0 + i, 32'h100 + 4 * i);
      tick();
    end
    drive(0, 0, 0);
    #1;
    chk("mid_count3", c4, 3);
    #2;
    rst_n = 0;
    #1;
    chk("async_count", c4, 0);
    chk("async_valid", ov4, 0);
    chk("async_ready", ir4, 1);
    #1;
    rst_n = 1;
    drive(1, 32'hAA, 32'h300);
    tick();
    drive(0, 0, 0);
    #1;
    chk("post_rst_valid", ov4, 1);
    chk("post_rst_data", od4, 32'hAA);
    chk("post_rst_addr", oa4, 32'h300);
    chk("post_rst_count", c4, 1);

    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h11 * (i + 1), 32'h100 + 4 * i);
      tick();
    end
    drive(1, 32'h55, 32'h500);
    out_ready = 1;
    #1;
    chk("full3_ready", ir3, 0);
    chk("full3_count", c3, 3);
    chk("full3_head", od3, 32'h11);
    tick();
    drive(0, 0, 0);
    out_ready = 0;
    #1;
    chk("full3_pop_count", c3, 2);
    drive(1, 32'h44, 32'h10C);
    tick();
    drive(0, 0, 0);
    #1;
    chk("wrap_count", c3, 3);
    out_ready = 1;
    #1;
    chk("wrap_d0", od3, 32'h22);
    chk("wrap_a0", oa3, 32'h104);
    tick();
    chk("wrap_d1", od3, 32'h33);
    chk("wrap_a1", oa3, 32'h108);
    tick();
    chk("wrap_d2", od3, 32'h44);
    chk("wrap_a2", oa3, 32'h10C);
    tick();
    chk("wrap_empty", ov3, 0);
    chk("wrap_count0", c3, 0);
    out_ready = 0;

    reset_pulse();
    drive(1, 32'h1, 32'h400);
    tick();
    drive(1, 32'h2, 32'h404);
    tick();
    drive(1, 32'h3, 32'h408);
    out_ready = 1;
    #1;
    chk("pp_head", od4, 32'h1);
    tick();
    out_ready = 0;
    chk("pp_count", c4, 2);
    chk("pp_next", od4, 32'h2);
    drive(1, 32'h4, 32'h40C);
    tick();
    drive(1, 32'h5, 32'h410);
    tick();
    chk("full4_count", c4, 4);
    drive(1, 32'h6, 32'h414);
    out_ready = 1;
    #1;
    chk("full4_ready", ir4, 0);
    chk("full4_valid", ov4, 1);
    tick();
    drive(0, 0, 0);
    chk("full4_pop_count", c4, 3);
    chk("drain_d0", od4, 32'h3);
    chk("drain_a0", oa4, 32'h408);
    tick();
    chk("drain_d1", od4, 32'h4);
    tick();
    chk("drain_d2", od4, 32'h5);
    tick();
    chk("drain_empty", ov4, 0);
    out_ready = 0;

    reset_pulse();
    drive(1, 32'h13, 32'h500);
    out_ready = 1;
    #1;
    chk("ft_valid", ovf, 1);
    chk("ft_data", odf, 32'h13);
    chk("ft_addr", oaf, 32'h500);
    chk("ft_count", cf, 0);
    chk("nft_valid", ov4, 0);
    tick();
    drive(0, 0, 0);
    out_ready = 0;
    #1;
    chk("ft_count_after", cf, 0);
    chk("ft_valid_after", ovf, 0);
    drive(1, 32'h93, 32'h504);
    tick();
    drive(0, 0, 0);
    #1;
    chk("ft_store_count", cf, 1);
    chk("ft_store_data", odf, 32'h93);

    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h60 + i, 32'h600 + 4 * i);
      tick();
    end
    drive(1, 32'h77, 32'h700);
    flush = 1;
    out_ready = 1;
    #1;
    chk("flush_valid", ov4, 0);
    chk("flush_ready", ir4, 0);
    tick();
    flush = 0;
    drive(0, 0, 0);
    out_ready = 0;
    #1;
    chk("flush_count", c4, 0);
    chk("flush_empty", ov4, 0);
    drive(1, 32'h88, 32'h800);
    tick();
    drive(0, 0, 0);
    #1;
    chk("flush_next_head", od4, 32'h88);
    chk("flush_next_count", c4, 1);

    reset_pulse();
    chk_en = 1;
    drive(1, 32'h99, 32'h200);
    tag = 1;
    hwlp = 1;
    tick();
    drive(0, 0, 0);
    tag = 0;
    hwlp = 0;
    #1;
    chk("tag_fault", tf4, 1);
    chk("tag_head_tag", ot4, 1);
    chk("tag_head_hwlp", oh4, 1);
    chk("tag_head_addr", oa4, 32'h200);
    chk("tag_sticky_pre", st4, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    #1;
    chk("tag_sticky_set", st4, 1);
    chk("tag_fault_gone", tf4, 0);
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("sticky_flush_only", st4, 1);
    flush = 1;
    clr = 1;
    tick();
    flush = 0;
    clr = 0;
    #1;
    chk("sticky_cleared", st4, 0);
    drive(1, 32'h9A, 32'h204);
    tag = 1;
    tick();
    drive(0, 0, 0);
    tag = 0;
    out_ready = 1;
    clr = 1;
    #1;
    chk("tag_fault2", tf4, 1);
    tick();
    out_ready = 0;
    clr = 0;
    #1;
    chk("sticky_set_wins", st4, 1);
    chk_en = 0;
    drive(1, 32'h9B, 32'h208);
    tag = 1;
    tick();
    drive(0, 0, 0);
    tag = 0;
    #1;
    chk("tag_check_off", tf4, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
